reg_wr_feeder: RTL and testbench

//   Upstream write-feeder for the 8-bit register with active-low write enable.

---
 rtl/reg_wr_pkg.sv | 21 ++
 rtl/reg_wr_fifo.sv | 78 +++++++
 rtl/reg_wr_feeder.sv | 122 ++++++++++++
 tb/tb_reg_wr_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_wr_pkg.sv
// ============================================================================
// Module      : reg_wr_pkg
// Description : Shared constants and FSM state encoding for the register
//               write feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_wr_pkg;

    localparam int c_DEFAULT_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STROBE = 2'd1;
    localparam state_t ST_GAP    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/reg_wr_fifo.sv
// ============================================================================
// Module      : reg_wr_fifo
// Description : Power-of-two synchronous FIFO buffering bytes for the feeder.
//               Occupancy port present only with REG_WR_FEEDER_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wr_fifo
    import reg_wr_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_empty,
    output logic                     o_full
`ifdef REG_WR_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   o_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

`ifdef REG_WR_FEEDER_LEVEL_EN
    assign o_count = r_count;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_wr_feeder.sv
// ============================================================================
// Module      : reg_wr_feeder
// Description : Buffers bytes from a valid/ready input and replays each one
//               as a one-cycle active-low register write strobe.
//               Optional macro REG_WR_FEEDER_LEVEL_EN adds the 'level' port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wr_feeder
    import reg_wr_pkg::*;
#(
    parameter int DATA_W     = c_DEFAULT_DATA_W,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     wr_en_n,
    output logic                     empty,
    output logic                     full
`ifdef REG_WR_FEEDER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    // The counter only has to hold GAP_CYCLES-1, since the final GAP cycle
    // doubles as the IDLE decision cycle.
    localparam int               c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int               c_GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(c_GAP_INIT);

    state_t              r_state;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en_n;
    logic [DATA_W-1:0]   w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_gap_done;

    reg_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
`ifdef REG_WR_FEEDER_LEVEL_EN
        ,
        .o_count (level)
`endif
    );

    assign in_ready = !w_full;
    assign empty    = w_empty;
    assign full     = w_full;
    assign wr_data  = r_wr_data;
    assign wr_en_n  = r_wr_en_n;

    always_comb begin
        w_gap_done = (r_gap_cnt == '0);
        w_pop      = 1'b0;
        if (!w_empty) begin
            case (r_state)
                ST_IDLE:   w_pop = 1'b1;
                ST_STROBE: w_pop = (GAP_CYCLES == 0);
                ST_GAP:    w_pop = w_gap_done;
                default:   w_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_wr_en_n <= 1'b1;
            r_wr_data <= '0;
        end else begin
            r_wr_en_n <= 1'b1;
            if (w_pop) begin
                r_wr_data <= w_head;
                r_wr_en_n <= 1'b0;
                r_state   <= ST_STROBE;
            end else begin
                case (r_state)
                    ST_STROBE: begin
                        if (GAP_CYCLES > 0) begin
                            r_gap_cnt <= c_GAP_LOAD;
                            r_state   <= ST_GAP;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (!w_gap_done) begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_wr_feeder.sv
// ============================================================================
// Module      : tb_reg_wr_feeder
// Description : Bench driving a GAP_CYCLES=1 and a GAP_CYCLES=0 feeder with
//               identical stimulus, each against a queue/timing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_wr_feeder;

    localparam int c_DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       a_ready, a_wr_en_n, a_empty, a_full;
    logic [7:0] a_wr_data;
    logic       b_ready, b_wr_en_n, b_empty, b_full;
    logic [7:0] b_wr_data;
`ifdef REG_WR_FEEDER_LEVEL_EN
    logic [2:0] a_level, b_level;
`endif

    always #5 clk = ~clk;

    reg_wr_feeder #(.DATA_W(8), .DEPTH(c_DEPTH), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_ready), .wr_data(a_wr_data), .wr_en_n(a_wr_en_n),
        .empty(a_empty), .full(a_full)
`ifdef REG_WR_FEEDER_LEVEL_EN
        , .level(a_level)
`endif
    );

    reg_wr_feeder #(.DATA_W(8), .DEPTH(c_DEPTH), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_ready), .wr_data(b_wr_data), .wr_en_n(b_wr_en_n),
        .empty(b_empty), .full(b_full)
`ifdef REG_WR_FEEDER_LEVEL_EN
        , .level(b_level)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a queue of accepted bytes plus the edge index of the last strobe.
    // A strobe fires at an edge whenever data is queued and at least GAP+1
    // edges have elapsed since the previous strobe.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         cyc    = 0;
    int         last_a = -100;
    int         last_b = -100;
    logic [7:0] da = 8'h00, db = 8'h00;
    logic       sa = 1'b0, sb = 1'b0;
    int         str_a = 0, str_b = 0;

    task automatic step(input logic v, input logic [7:0] d, input logic r, output bit accepted);
        bit pa, pb;
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        @(posedge clk);
        cyc++;
        accepted = 1'b0;
        if (!r) begin
            qa.delete(); qb.delete();
            da = 8'h00; db = 8'h00; sa = 1'b0; sb = 1'b0;
            last_a = -100; last_b = -100;
        end else begin
            sa = (qa.size() != 0) && (cyc - last_a >= 2);
            sb = (qb.size() != 0) && (cyc - last_b >= 1);
            pa = v && (qa.size() < c_DEPTH);
            pb = v && (qb.size() < c_DEPTH);
            if (sa) begin da = qa.pop_front(); last_a = cyc; end
            if (sb) begin db = qb.pop_front(); last_b = cyc; end
            if (pa) qa.push_back(d);
            if (pb) qb.push_back(d);
            accepted = pa;
        end
        #1;
        if (!a_wr_en_n) str_a++;
        if (!b_wr_en_n) str_b++;
        check("a_wr_en_n", a_wr_en_n, !sa);
        check("a_wr_data", a_wr_data, da);
        check("a_empty",   a_empty,   qa.size() == 0);
        check("a_full",    a_full,    qa.size() == c_DEPTH);
        check("a_ready",   a_ready,   qa.size() <  c_DEPTH);
        check("b_wr_en_n", b_wr_en_n, !sb);
        check("b_wr_data", b_wr_data, db);
        check("b_empty",   b_empty,   qb.size() == 0);
        check("b_full",    b_full,    qb.size() == c_DEPTH);
        check("b_ready",   b_ready,   qb.size() <  c_DEPTH);
`ifdef REG_WR_FEEDER_LEVEL_EN
        check("a_level",   a_level,   qa.size());
        check("b_level",   b_level,   qb.size());
`endif
    endtask

    initial begin
        bit acc;
        int i;
        int guard;

        // Reset and single byte latency
        repeat (2) step(1'b0, 8'h00, 1'b0, acc);
        check("rst_wr_en_n", a_wr_en_n, 1'b1);
        check("rst_wr_data", a_wr_data, 8'h00);
        step(1'b1, 8'hA5, 1'b1, acc);
        check("one_accept_no_strobe", a_wr_en_n, 1'b1);
        step(1'b0, 8'h00, 1'b1, acc);
        check("one_strobe_low", a_wr_en_n, 1'b0);
        check("one_strobe_data", a_wr_data, 8'hA5);
        step(1'b0, 8'h00, 1'b1, acc);
        check("one_strobe_high", a_wr_en_n, 1'b1);
        check("one_data_held", a_wr_data, 8'hA5);
        repeat (3) step(1'b0, 8'h00, 1'b1, acc);

        // Continuous stream 0..255
        step(1'b0, 8'h00, 1'b0, acc);
        str_a = 0;
        i = 0;
        guard = 0;
        while (i < 256 && guard < 2000) begin
            step(1'b1, 8'(i), 1'b1, acc);
            if (acc) i++;
            guard++;
        end
        check("stream_accepted", i, 256);
        repeat (20) step(1'b0, 8'h00, 1'b1, acc);
        check("stream_strobes", str_a, 256);
        check("stream_last_data", a_wr_data, 8'hFF);

        // Back-to-back burst of four
        step(1'b0, 8'h00, 1'b0, acc);
        str_b = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 8'(k), 1'b1, acc);
        repeat (8) step(1'b0, 8'h00, 1'b1, acc);
        check("burst_b_strobes", str_b, 4);
        check("burst_b_last", b_wr_data, 8'h03);

        // Hold in_valid with FF against a full FIFO
        step(1'b0, 8'h00, 1'b0, acc);
        repeat (16) step(1'b1, 8'hFF, 1'b1, acc);
        repeat (16) step(1'b0, 8'h00, 1'b1, acc);

        // Reset with three entries queued and a strobe in flight
        step(1'b0, 8'h00, 1'b0, acc);
        for (int k = 1; k <= 6; k++) step(1'b1, 8'(k), 1'b1, acc);
        check("pre_rst_strobe", a_wr_en_n, 1'b0);
        check("pre_rst_queued", qa.size(), 3);
        step(1'b0, 8'h00, 1'b0, acc);
        check("mid_rst_wr_en_n", a_wr_en_n, 1'b1);
        check("mid_rst_empty", a_empty, 1'b1);
        check("mid_rst_wr_data", a_wr_data, 8'h00);
        str_a = 0;
        repeat (6) step(1'b0, 8'h00, 1'b1, acc);
        check("post_rst_no_strobe", str_a, 0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 63) == 0)
                step(1'b0, 8'h00, 1'b0, acc);
            else
                step($urandom_range(0, 9) < 7, 8'($urandom), 1'b1, acc);
        end
        repeat (12) step(1'b0, 8'h00, 1'b1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
